// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register-file write port
// Combinational grant from rr_ptr upward; registered write port with one cycle of latency.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_data,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [WIDTH-1:0]              wr_data,
    output logic [IDW-1:0]                grant_id,
    output logic [CNT_WIDTH-1:0]          contention_cnt
);

    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        win;
    logic                  found;
    logic                  grant;
    logic                  multi;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [WIDTH-1:0]      win_data;
    int                    nvalid;

    // Two descending scans: the first picks the lowest valid index at or above
    // rr_ptr, the second (wrap-around) the lowest valid index overall.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(rr_ptr))) begin
                win   = IDW'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    win   = IDW'(i);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        nvalid = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            nvalid = nvalid + int'(req_valid[i]);
        end
    end

    assign multi     = (nvalid >= 2);
    assign grant     = found && !stall && !rst;
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
    assign win_addr  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data  = req_data[int'(win)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr         <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            grant_id       <= '0;
            contention_cnt <= '0;
        end else begin
            // Writes to x0 are accepted but never reach the register file.
            wr_en <= grant && (win_addr != '0);
            if (grant) begin
                wr_addr  <= win_addr;
                wr_data  <= win_data;
                grant_id <= win;
                rr_ptr   <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
            end
            if (multi && (contention_cnt != {CNT_WIDTH{1'b1}})) begin
                contention_cnt <= contention_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ write-back sources: ALU, load unit and CSR unit.
- Uses round-robin arbitration with valid/ready handshakes on the request side.
- Drives a registered write port: wr_en, wr_addr and wr_data feed the register file's per-register enables and data inputs, with one cycle of latency.
- Sits between the execute/memory stages and the register file.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- WIDTH, 32, data width of each register.
- ADDR_WIDTH, 5, register index width (32 architectural registers).
- CNT_WIDTH, 16, width of the saturating contention counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  when high, blocks all grants this cycle.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester grant (one-hot or zero).
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination indices; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*WIDTH  packed write data, packed the same way.
- wr_en  output  1  register-file write enable (registered).
- wr_addr  output  ADDR_WIDTH  register-file write index (registered).
- wr_data  output  WIDTH  register-file write data (registered).
- grant_id  output  $clog2(NUM_REQ)  index of the last accepted requester (registered).
- contention_cnt  output  CNT_WIDTH  saturating count of cycles with more than one req_valid high.

Behaviour:
- Reset (async, rst=1): rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0, contention_cnt=0. req_ready is combinational and must be 0 while rst is high.
- Arbitration is combinational in the current cycle:
  - Search requesters starting at rr_ptr, ascending, wrapping at NUM_REQ-1 to 0.
  - The first i with req_valid[i]=1 wins.
  - req_ready[winner]=1 iff !stall && !rst; all other bits are 0.
- Transfer happens when req_valid[i] && req_ready[i]. Exactly zero or one transfer occurs per cycle.
- Requester protocol (checked by the bench, not the DUT): once req_valid[i] is high, it must stay high and req_addr/req_data must stay stable until the transfer.
- Latency: on the edge ending a transfer cycle from requester k:
  - wr_en <= (req_addr[k] != 0).
  - wr_addr <= req_addr[k], wr_data <= req_data[k], grant_id <= k.
- x0 suppression: a transfer with address 0 is accepted (ready=1, pointer advances) but wr_en=0; wr_addr and wr_data still update.
- No transfer in a cycle: wr_en <= 0 on that edge; wr_addr, wr_data and grant_id hold. wr_en is a one-cycle pulse per transfer and is never held across a stall.
- Pointer: after a transfer by k, rr_ptr <= (k+1) mod NUM_REQ; otherwise rr_ptr holds.
- Fairness bound: a continuously valid requester is granted within NUM_REQ non-stalled cycles.
- Back-to-back operation: a requester may transfer on consecutive cycles only if it is the sole valid requester.
- Stall:
  - All req_ready are 0 and rr_ptr holds.
  - wr_en is 0 on the next edge.
  - Stalling does not alter the arbitration order.
- contention_cnt:
  - Increments by 1 on each edge where popcount(req_valid) >= 2, regardless of stall.
  - Saturates at 2^CNT_WIDTH-1 (no wrap).
  - Clears only on reset.
- Reset mid-operation:
  - Any pending write-port update is discarded: wr_en goes to 0 immediately (async).
  - req_ready drops within the same cycle.
  - After rst falls, arbitration restarts at requester 0.
- Width rules: requester slices are extracted by fixed offset, with no sign extension.

Test Plan:
- Reset: hold rst 5 cycles with all req_valid=1 -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0, contention_cnt=0. Release rst -> requester 0 granted in the first cycle.
- Single requester: req_valid=3'b010, addr=5, data=32'hDEADBEEF for 1 cycle -> req_ready=3'b010 that cycle. Next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF, grant_id=1. The following cycle wr_en=0.
- Round-robin: all three valid continuously for 6 cycles with addresses 1/2/3 -> grant order 0,1,2,0,1,2; wr_addr sequence 1,2,3,1,2,3 one cycle later; contention_cnt=6.
- x0 write: requester 2 with addr=0, data=32'hFFFFFFFF -> req_ready[2]=1, then wr_en=0 next cycle, rr_ptr advances to 0 (a later 0-and-2 conflict grants 0).
- Stall: all valid, stall=1 for 3 cycles, then 0 -> no ready and wr_en=0 during the stall; the first grant after the stall is the same requester that would have won before it. contention_cnt still increments by 3.
- Saturation and async reset: CNT_WIDTH=4, 20 contended cycles -> contention_cnt=15 and holds. Assert rst between edges -> wr_en and contention_cnt are 0 before the next rising clk.
- Random soak (10000 cycles, random valid/stall, protocol-compliant):
  - Assertions: req_ready one-hot-or-zero; wr_en |-> $past(transfer && addr != 0); starvation bound of NUM_REQ cycles.
  - Cover each grant_id, stall with all valid, and addr=0 accepted.
